// File: rtl/ext_unit_pipe.sv
// Registered IN_W->OUT_W zero/sign/upper extender (upper placement only with EXT_LUI_EN), 1-cycle latency.
// Backpressure: 2-entry skid buffer; in_ready drops only while both entries are held.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [OUT_W-1:0] dat;
    logic [TAG_W-1:0] tag;
  } ent_t;

  state_t state;
  ent_t   out_ent;
  ent_t   skid_ent;
  ent_t   ext_ent;
  logic   in_xfer;
  logic   out_xfer;

  // Extension happens before the register so held entries are already final.
  always_comb begin
    ext_ent.tag = in_tag;
    ext_ent.dat = {{PAD{1'b0}}, in_data};
    case (in_mode)
      2'b01:   ext_ent.dat = {{PAD{in_data[IN_W-1]}}, in_data};
`ifdef EXT_LUI_EN
      2'b10:   ext_ent.dat = OUT_W'(in_data) << PAD;
`endif
      default: ext_ent.dat = {{PAD{1'b0}}, in_data};
    endcase
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign busy      = (state != EMPTY);
  assign out_data  = out_ent.dat;
  assign out_tag   = out_ent.tag;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_ent  <= '0;
      skid_ent <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_ent <= ext_ent;
            state   <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_ent <= ext_ent;
          end else if (in_xfer) begin
            skid_ent <= ext_ent;
            state    <= TWO;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            out_ent <= skid_ent;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
